fp_add_normalize: RTL and testbench

- Sequential add/normalize stage directly downstream of the exponent-alignment stage in the floating-point adder datapath.
- Accepts the larger operand (bign) and the aligned smaller operand, which already carries bign's exponent.
- Adds or subtracts the significands according to the signs, then normalizes with a multi-cycle left-shift loop.
- Presents a normalized fp_t result with status flags over a valid/ready handshake.

---
 rtl/fp_add_normalize.sv | 218 +++++++++++++++++++++
 tb/tb_fp_add_normalize.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/fp_add_normalize.sv
// fp_add_normalize: add/normalize stage that sits after exponent alignment.
// Adds or subtracts the significands of the larger operand (bign) and the
// aligned smaller operand, then left-normalizes the result. Only one
// operation is in flight at a time.
// Optional build macro FP_NORM_FAST_EN: replaces the one-bit-per-cycle
// normalize loop with a single-cycle leading-zero shift. Results, flags and
// the handshake are identical; only the latency changes.
// Operand and result layout is {sign, exp, frac}, which matches
// FloatingPointPkg::fp_t.

package FloatingPointPkg;
   localparam int EXP_W  = 4;
   localparam int FRAC_W = 8;
   typedef struct packed {
      logic              sign;
      logic [EXP_W-1:0]  exp;
      logic [FRAC_W-1:0] frac;
   } fp_t;
endpackage

module fp_add_normalize #(
   parameter int EXP_W  = FloatingPointPkg::EXP_W,
   parameter int FRAC_W = FloatingPointPkg::FRAC_W
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [EXP_W+FRAC_W:0]   bign,
   input  logic [EXP_W+FRAC_W:0]   aligned,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [EXP_W+FRAC_W:0]   result,
   output logic                    ovf,
   output logic                    unf,
   output logic                    zero
);

   localparam int              SW      = EXP_W + FRAC_W;
   localparam logic [EXP_W-1:0] EXP_MAX = {EXP_W{1'b1}};

`ifdef FP_NORM_FAST_EN
   typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;
`else
   typedef enum logic [1:0] {IDLE, ADD, NORM, DONE} state_t;
`endif

   state_t state, nxt_state;

   // captured operands; aligned.exp equals bign.exp so only its sign/frac are kept
   logic              big_sign, al_sign;
   logic [EXP_W-1:0]  big_exp;
   logic [FRAC_W-1:0] big_frac, al_frac;

   // result registers, doubling as the working value during normalization
   logic              r_sign, nxt_sign;
   logic [EXP_W-1:0]  r_exp, nxt_exp;
   logic [FRAC_W-1:0] r_frac, nxt_frac;
   logic              ovf_q, unf_q, zero_q;
   logic              nxt_ovf, nxt_unf, nxt_zero;

   logic [FRAC_W:0]   sum;
   logic              sum_sign;
   logic [FRAC_W-1:0] norm_frac;
   logic [EXP_W-1:0]  norm_exp;

   // aligned.exp is redundant with bign.exp by construction
   logic unused_al_exp;
   assign unused_al_exp = ^aligned[SW-1:FRAC_W];

`ifdef FP_NORM_FAST_EN
   int               lz;
   logic [EXP_W-1:0] sh;
`endif

   assign in_ready  = (state == IDLE) && !rst;
   assign out_valid = (state == DONE);
   assign result    = {r_sign, r_exp, r_frac};
   assign ovf       = ovf_q;
   assign unf       = unf_q;
   assign zero      = zero_q;

   // next-state and next-datapath values for every state
   always_comb begin
      nxt_state = state;
      nxt_sign  = r_sign;
      nxt_exp   = r_exp;
      nxt_frac  = r_frac;
      nxt_ovf   = ovf_q;
      nxt_unf   = unf_q;
      nxt_zero  = zero_q;
      norm_frac = '0;
      norm_exp  = '0;
`ifdef FP_NORM_FAST_EN
      lz        = FRAC_W;
      sh        = '0;
`endif

      // magnitude add/subtract; the larger significand sets the sign
      if (big_sign == al_sign) begin
         sum      = {1'b0, big_frac} + {1'b0, al_frac};
         sum_sign = big_sign;
      end else if (al_frac > big_frac) begin
         sum      = {1'b0, al_frac} - {1'b0, big_frac};
         sum_sign = al_sign;
      end else begin
         sum      = {1'b0, big_frac} - {1'b0, al_frac};
         sum_sign = big_sign;
      end

      case (state)
         IDLE: begin
            if (in_valid && in_ready) begin
               nxt_state = ADD;
               nxt_ovf   = 1'b0;
               nxt_unf   = 1'b0;
               nxt_zero  = 1'b0;
            end
         end

         ADD: begin
            nxt_sign = sum_sign;
            nxt_exp  = big_exp;
            nxt_frac = sum[FRAC_W-1:0];
            if (sum[FRAC_W]) begin
               nxt_state = DONE;
               if (big_exp != EXP_MAX) begin
                  nxt_frac = sum[FRAC_W:1];
                  nxt_exp  = big_exp + 1'b1;
               end else begin
                  nxt_frac = '1;
                  nxt_exp  = EXP_MAX;
                  nxt_ovf  = 1'b1;
               end
            end else if (sum == '0) begin
               // exact cancellation always yields +0
               nxt_state = DONE;
               nxt_sign  = 1'b0;
               nxt_exp   = '0;
               nxt_frac  = '0;
               nxt_zero  = 1'b1;
            end else if (sum[FRAC_W-1] || (big_exp == '0)) begin
               nxt_state = DONE;
               nxt_unf   = !sum[FRAC_W-1];
            end else begin
`ifdef FP_NORM_FAST_EN
               // highest set bit wins; shift is clamped so exp stops at 0
               for (int i = 0; i < FRAC_W; i++)
                  if (sum[i]) lz = FRAC_W - 1 - i;
               if (lz > int'(big_exp)) sh = big_exp;
               else                    sh = EXP_W'(lz);
               norm_frac = sum[FRAC_W-1:0] << sh;
               norm_exp  = big_exp - sh;
               nxt_frac  = norm_frac;
               nxt_exp   = norm_exp;
               nxt_unf   = (norm_exp == '0) && !norm_frac[FRAC_W-1];
               nxt_state = DONE;
`else
               nxt_state = NORM;
`endif
            end
         end

`ifndef FP_NORM_FAST_EN
         NORM: begin
            norm_frac = r_frac << 1;
            norm_exp  = r_exp - 1'b1;
            nxt_frac  = norm_frac;
            nxt_exp   = norm_exp;
            if (norm_frac[FRAC_W-1] || (norm_exp == '0)) begin
               nxt_state = DONE;
               nxt_unf   = !norm_frac[FRAC_W-1];
            end
         end
`endif

         DONE: begin
            if (out_ready) nxt_state = IDLE;
         end

         default: nxt_state = IDLE;
      endcase
   end

   // state, result and operand registers; reset drops any operation in flight
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         r_sign   <= 1'b0;
         r_exp    <= '0;
         r_frac   <= '0;
         ovf_q    <= 1'b0;
         unf_q    <= 1'b0;
         zero_q   <= 1'b0;
         big_sign <= 1'b0;
         big_exp  <= '0;
         big_frac <= '0;
         al_sign  <= 1'b0;
         al_frac  <= '0;
      end else begin
         state  <= nxt_state;
         r_sign <= nxt_sign;
         r_exp  <= nxt_exp;
         r_frac <= nxt_frac;
         ovf_q  <= nxt_ovf;
         unf_q  <= nxt_unf;
         zero_q <= nxt_zero;
         if (in_valid && in_ready) begin
            big_sign <= bign[SW];
            big_exp  <= bign[SW-1:FRAC_W];
            big_frac <= bign[FRAC_W-1:0];
            al_sign  <= aligned[SW];
            al_frac  <= aligned[FRAC_W-1:0];
         end
      end
   end

endmodule

// File: tb/tb_fp_add_normalize.sv
// Bench for fp_add_normalize (EXP_W=4, FRAC_W=8): directed cases followed by
// random operand pairs checked against an integer-arithmetic reference.

module tb_fp_add_normalize;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [12:0] bign;
   logic [12:0] aligned;
   logic        out_valid;
   logic        out_ready;
   logic [12:0] result;
   logic        ovf;
   logic        unf;
   logic        zero;

   int total = 0;
   int bad   = 0;

   fp_add_normalize #(.EXP_W(4), .FRAC_W(8)) dut (
      .clk      (clk),
      .rst      (rst),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .bign     (bign),
      .aligned  (aligned),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .result   (result),
      .ovf      (ovf),
      .unf      (unf),
      .zero     (zero)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      total++;
      assert (obs === expv) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   // signed-integer reference: add, then shift left until normalized or exp hits 0
   function automatic void model(input logic [12:0] b, input logic [12:0] a,
                                 output logic [12:0] r, output logic o,
                                 output logic u, output logic z, output int k);
      int   s, mag, e;
      logic sg;
      s  = (b[12] ? -int'(b[7:0]) : int'(b[7:0])) + (a[12] ? -int'(a[7:0]) : int'(a[7:0]));
      e  = int'(b[11:8]);
      sg = (s < 0);
      mag = sg ? -s : s;
      k = 0; o = 1'b0; u = 1'b0; z = 1'b0;
      if (mag == 0) begin
         r = 13'h0;
         z = 1'b1;
      end else if (mag > 255) begin
         if (e < 15) r = {sg, 4'(e + 1), 8'(mag / 2)};
         else begin
            r = {sg, 4'hF, 8'hFF};
            o = 1'b1;
         end
      end else begin
         while (mag < 128 && e > 0) begin
            mag = mag * 2;
            e   = e - 1;
            k++;
         end
         u = (mag < 128);
         r = {sg, 4'(e), 8'(mag)};
      end
   endfunction

   // one full transaction; hold>0 keeps out_ready low in DONE and offers a second input
   task automatic do_op(input logic [12:0] b, input logic [12:0] a, input int hold);
      logic [12:0] er;
      logic        eo, eu, ez;
      int          k, lat, n;
      model(b, a, er, eo, eu, ez, k);
`ifdef FP_NORM_FAST_EN
      k = 0;
`endif
      n = 0;
      while (!in_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      check("in_ready_idle", 32'(in_ready), 32'd1);
      bign     = b;
      aligned  = a;
      in_valid = 1'b1;
      @(posedge clk);
      lat = 1;
      @(negedge clk);
      in_valid = 1'b0;
      bign     = 13'($urandom);
      aligned  = 13'($urandom);
      while (!out_valid && lat < 40) begin
         @(posedge clk);
         lat++;
         @(negedge clk);
      end
      check("out_valid", 32'(out_valid), 32'd1);
      check("latency", 32'(lat), 32'(2 + k));
      check("result", 32'(result), 32'(er));
      check("flags", 32'({ovf, unf, zero}), 32'({eo, eu, ez}));
      check("in_ready_busy", 32'(in_ready), 32'd0);
      for (int h = 0; h < hold; h++) begin
         in_valid = 1'b1;
         @(posedge clk);
         @(negedge clk);
         check("hold_valid", 32'(out_valid), 32'd1);
         check("hold_result", 32'(result), 32'(er));
         check("hold_flags", 32'({ovf, unf, zero}), 32'({eo, eu, ez}));
         check("hold_in_ready", 32'(in_ready), 32'd0);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      out_ready = 1'b0;
      check("release_valid", 32'(out_valid), 32'd0);
      check("release_in_ready", 32'(in_ready), 32'd1);
   endtask

   initial begin
      logic [12:0] rb, ra;
      logic        seen;
      rst       = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      bign      = '0;
      aligned   = '0;
      repeat (3) @(negedge clk);
      check("rst_in_ready", 32'(in_ready), 32'd0);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_result", 32'(result), 32'd0);
      check("rst_flags", 32'({ovf, unf, zero}), 32'd0);
      rst = 1'b0;
      @(negedge clk);

      // directed cases
      do_op({1'b0, 4'd5, 8'h80}, {1'b0, 4'd5, 8'h40}, 0);   // plain add
      do_op({1'b0, 4'd5, 8'h80}, {1'b0, 4'd5, 8'h80}, 0);   // carry
      do_op({1'b0, 4'd15, 8'hFF}, {1'b0, 4'd15, 8'h01}, 0); // overflow
      do_op({1'b0, 4'd9, 8'h80}, {1'b1, 4'd9, 8'h7F}, 0);   // 7-shift cancellation
      do_op({1'b0, 4'd4, 8'h40}, {1'b1, 4'd4, 8'h60}, 0);   // aligned larger
      do_op({1'b0, 4'd3, 8'h55}, {1'b1, 4'd3, 8'h55}, 0);   // exact zero
      do_op({1'b0, 4'd1, 8'h40}, {1'b1, 4'd1, 8'h30}, 0);   // underflow
      do_op({1'b1, 4'd0, 8'h10}, {1'b1, 4'd0, 8'h20}, 0);   // exp 0, unnormalized
      do_op({1'b0, 4'd7, 8'hC3}, {1'b0, 4'd7, 8'h11}, 5);   // backpressure

      // reset in the middle of an operation
      bign     = {1'b0, 4'd9, 8'h80};
      aligned  = {1'b1, 4'd9, 8'h7F};
      in_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check("midrst_out_valid", 32'(out_valid), 32'd0);
      check("midrst_result", 32'(result), 32'd0);
      check("midrst_flags", 32'({ovf, unf, zero}), 32'd0);
      check("midrst_in_ready", 32'(in_ready), 32'd0);
      rst = 1'b0;
      @(negedge clk);
      check("postrst_in_ready", 32'(in_ready), 32'd1);
      seen = 1'b0;
      repeat (12) begin
         @(negedge clk);
         if (out_valid) seen = 1'b1;
      end
      check("no_stale_result", 32'(seen), 32'd0);

      // random operand pairs, biased toward near-cancellation
      for (int i = 0; i < 60; i++) begin
         rb = {1'($urandom), 4'($urandom), 8'($urandom)};
         ra[12]   = 1'($urandom);
         ra[11:8] = rb[11:8];
         if ($urandom_range(0, 2) == 0) ra[7:0] = rb[7:0] - 8'($urandom_range(0, 15));
         else                           ra[7:0] = 8'($urandom);
         do_op(rb, ra, (i % 10 == 0) ? 2 : 0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
